// File: rtl/pc_sequencer_pkg.sv
// Shared constants and FSM encoding for the PC sequencer and its return-address stack.
package pc_sequencer_pkg;

  localparam int PC_W          = 8;
  localparam int RAS_DEPTH_DEF = 4;

  localparam logic [PC_W-1:0] PC_INC    = PC_W'(4);
  localparam logic [PC_W-1:0] RESET_VEC = '0;

  typedef enum logic {
    RUN   = 1'b0,
    DELAY = 1'b1
  } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Branch-resolution and PC-queue signals between the target generator/fetch side and the sequencer.
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  // Handshake: br_valid qualifies all br_* fields for the instruction at front_pc; there is
  // no ready. While stall=1 the sequencer takes nothing and the producer holds br_* steady.
  logic            stall;
  logic            br_valid;
  logic            br_taken;
  logic [PC_W-1:0] br_ta;
  logic [PC_W-1:0] ret_addr;
  logic            br_link;
  logic            br_ret;
  logic            br_nullify;

  logic [PC_W-1:0]  front_pc;
  logic [PC_W-1:0]  back_pc;
  logic             nullify_front;
  logic             ras_empty;
  logic             delay_br_err;
  state_t           state_dbg;
  logic [CNT_W-1:0] ras_count_dbg;

  modport master (
    output stall, br_valid, br_taken, br_ta, ret_addr, br_link, br_ret, br_nullify,
    input  front_pc, back_pc, nullify_front, ras_empty, delay_br_err, state_dbg, ras_count_dbg
  );

  modport slave (
    input  stall, br_valid, br_taken, br_ta, ret_addr, br_link, br_ret, br_nullify,
    output front_pc, back_pc, nullify_front, ras_empty, delay_br_err, state_dbg, ras_count_dbg
  );

endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack: push, pop, or replace-top when both are requested on a non-empty stack.
module ras_stack #(
  parameter int RAS_DEPTH = 4,
  parameter int PC_W      = 8,
  localparam int PTR_W    = $clog2(RAS_DEPTH),
  localparam int CNT_W    = $clog2(RAS_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [PC_W-1:0]  i_wdata,
  output logic [PC_W-1:0]  o_top,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);

  logic [PC_W-1:0]  r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_empty;
  logic             w_replace;
  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_top_idx;

  // r_ptr names the next free slot, so the top lives one below it (mod depth).
  assign w_top_idx = r_ptr - PTR_W'(1);
  assign w_empty   = (r_count == '0);
  assign w_replace = i_push && i_pop && !w_empty;
  assign w_push    = i_push && !w_replace;
  assign w_pop     = i_pop && !i_push && !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_push) begin
      r_ptr <= r_ptr + PTR_W'(1);
      if (r_count != CNT_W'(RAS_DEPTH)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end else if (w_pop) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_ptr] <= i_wdata;
    end else if (w_replace) begin
      r_mem[w_top_idx] <= i_wdata;
    end
  end

  assign o_top   = r_mem[w_top_idx];
  assign o_count = r_count;
  assign o_empty = w_empty;

endmodule

// File: rtl/pc_sequencer.sv
// PA-RISC front/back PC queue with delayed-branch FSM, optional delay-slot nullify and return-address stack.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_null;
  logic            w_null_nxt;
  logic [PC_W-1:0] r_front;
  logic [PC_W-1:0] r_back;
  logic            r_err;

  logic             w_adv;
  logic             w_br_live;
  logic             w_taken;
  logic [PC_W-1:0]  w_tgt;
  logic [PC_W-1:0]  w_ras_top;
  logic [CNT_W-1:0] w_ras_count;
  logic             w_ras_empty;

  assign w_adv     = !bus.stall;
  // A squashed delay slot is not a real instruction, so its br_valid means nothing.
  assign w_br_live = bus.br_valid && !r_null;
  assign w_taken   = w_adv && (r_state == RUN) && w_br_live && bus.br_taken;
  assign w_tgt     = (bus.br_ret && !w_ras_empty) ? w_ras_top : bus.br_ta;

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .PC_W      (PC_W)
  ) u_ras (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_taken && bus.br_link),
    .i_pop   (w_taken && bus.br_ret),
    .i_wdata (bus.ret_addr),
    .o_top   (w_ras_top),
    .o_count (w_ras_count),
    .o_empty (w_ras_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_null_nxt  = r_null;
    if (w_adv) begin
      case (r_state)
        RUN: begin
          if (w_taken) begin
            w_state_nxt = DELAY;
            w_null_nxt  = bus.br_nullify;
          end else begin
            w_null_nxt  = 1'b0;
          end
        end
        DELAY: begin
          w_state_nxt = RUN;
          w_null_nxt  = 1'b0;
        end
        default: begin
          w_state_nxt = RUN;
          w_null_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_null  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_null  <= w_null_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_front <= RESET_VEC;
      r_back  <= RESET_VEC + PC_INC;
      r_err   <= 1'b0;
    end else if (w_adv) begin
      r_front <= r_back;
      r_back  <= w_taken ? w_tgt : r_back + PC_INC;
      if ((r_state == DELAY) && w_br_live) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.front_pc      = r_front;
  assign bus.back_pc       = r_back;
  assign bus.nullify_front = r_null;
  assign bus.ras_empty     = w_ras_empty;
  assign bus.delay_br_err  = r_err;
  assign bus.state_dbg     = r_state;
  assign bus.ras_count_dbg = w_ras_count;

endmodule
